// File: rtl/cpr_bank.sv
// Control-processor register bank: STATUS/EPC/CAUSE/INST, interrupt mask/pending, cycle/instr/event counters.
// Optional macro CPR_EVT_OVF_EN adds a sticky event-counter overflow register at index 8+NUM_EVT.
module cpr_bank #(
  parameter int IDX_W   = 5,
  parameter int CAUSE_W = 6,
  parameter int IRQ_N   = 8,
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               cpr_op,
  input  logic [IDX_W-1:0]   cpr_idx,
  input  logic [63:0]        cpr_wdata,
  input  logic               e_enter,
  input  logic               e_exit,
  input  logic [63:0]        n_epc,
  input  logic [31:0]        n_inst,
  input  logic [CAUSE_W-1:0] n_cause,
  input  logic               instn_grad_gr,
  input  logic [IRQ_N-1:0]   irq_in,
  input  logic [NUM_EVT-1:0] evt_in,
  output logic               irq_req,
  output logic               rvalid,
  output logic [63:0]        result
);

  localparam logic [IDX_W-1:0] IX_STATUS = IDX_W'(0);
  localparam logic [IDX_W-1:0] IX_EPC    = IDX_W'(1);
  localparam logic [IDX_W-1:0] IX_CAUSE  = IDX_W'(2);
  localparam logic [IDX_W-1:0] IX_INST   = IDX_W'(3);
  localparam logic [IDX_W-1:0] IX_IMASK  = IDX_W'(4);
  localparam logic [IDX_W-1:0] IX_IPND   = IDX_W'(5);
  localparam logic [IDX_W-1:0] IX_ICNT   = IDX_W'(6);
  localparam logic [IDX_W-1:0] IX_CC     = IDX_W'(7);
  localparam logic [IDX_W-1:0] IX_OVF    = IDX_W'(8 + NUM_EVT);

  logic               r_emode, r_ie;
  logic [63:0]        r_epc;
  logic [CAUSE_W-1:0] r_cause;
  logic [31:0]        r_inst;
  logic [IRQ_N-1:0]   r_imask, r_ipnd;
  logic [CNT_W-1:0]   r_icnt, r_cc;
  logic               r_irq_req, r_rvalid;
  logic [63:0]        r_result;

  logic                     w_wr;
  logic [IRQ_N-1:0]         w_ipnd_clr;
  logic [NUM_EVT-1:0][63:0] w_evt_rd;
  logic [NUM_EVT-1:0]       w_evt_wr;
  logic [63:0]              w_ovf_rd;
  logic                     w_ovf_pend;
  logic [63:0]              w_rdata;

  assign w_wr       = enable & cpr_op;
  assign w_ipnd_clr = (w_wr && cpr_idx == IX_IPND) ? cpr_wdata[IRQ_N-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_emode <= 1'b1;
      r_ie    <= 1'b0;
    end else if (e_enter) begin
      r_emode <= 1'b1;
      r_ie    <= 1'b0;
    end else if (e_exit) begin
      r_emode <= 1'b0;
      r_ie    <= 1'b1;
    end else if (w_wr && cpr_idx == IX_STATUS) begin
      r_emode <= cpr_wdata[0];
      r_ie    <= cpr_wdata[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_epc   <= '0;
      r_cause <= '0;
      r_inst  <= '0;
    end else if (e_enter) begin
      r_epc   <= n_epc;
      r_cause <= n_cause;
      r_inst  <= n_inst;
    end else if (w_wr && cpr_idx == IX_EPC) begin
      r_epc   <= cpr_wdata;
    end
  end

  // Pending bits are write-1-to-clear; a live source re-sets in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_imask <= '0;
      r_ipnd  <= '0;
    end else begin
      r_ipnd <= (r_ipnd & ~w_ipnd_clr) | irq_in;
      if (w_wr && cpr_idx == IX_IMASK) r_imask <= cpr_wdata[IRQ_N-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_icnt <= '0;
      r_cc   <= '0;
    end else begin
      if (w_wr && cpr_idx == IX_ICNT) r_icnt <= cpr_wdata[CNT_W-1:0];
      else if (instn_grad_gr)         r_icnt <= r_icnt + 1'b1;
      if (w_wr && cpr_idx == IX_CC)   r_cc   <= cpr_wdata[CNT_W-1:0];
      else                            r_cc   <= r_cc + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_EVT; gi++) begin : g_evt
      logic [CNT_W-1:0] r_cnt;
      assign w_evt_wr[gi] = w_wr && (cpr_idx == IDX_W'(8 + gi));
      always_ff @(posedge clk) begin
        if (reset)              r_cnt <= '0;
        else if (w_evt_wr[gi])  r_cnt <= cpr_wdata[CNT_W-1:0];
        else if (evt_in[gi])    r_cnt <= r_cnt + 1'b1;
      end
      assign w_evt_rd[gi] = 64'(r_cnt);
    end
  endgenerate

`ifdef CPR_EVT_OVF_EN
  // Layout: [NUM_EVT-1:0] sticky ovf (W1C), [32+NUM_EVT-1:32] per-counter mask, [63] global enable.
  logic [NUM_EVT-1:0] r_ovf, r_ovf_mask;
  logic               r_ovf_gen;
  logic [NUM_EVT-1:0] w_evt_wrap;
  logic [NUM_EVT-1:0] w_ovf_clr;

  generate
    for (genvar gi = 0; gi < NUM_EVT; gi++) begin : g_wrap
      assign w_evt_wrap[gi] = evt_in[gi] & ~w_evt_wr[gi] & (&w_evt_rd[gi][CNT_W-1:0]);
    end
  endgenerate

  assign w_ovf_clr = (w_wr && cpr_idx == IX_OVF) ? cpr_wdata[NUM_EVT-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf      <= '0;
      r_ovf_mask <= '0;
      r_ovf_gen  <= 1'b0;
    end else begin
      r_ovf <= (r_ovf & ~w_ovf_clr) | w_evt_wrap;
      if (w_wr && cpr_idx == IX_OVF) begin
        r_ovf_mask <= cpr_wdata[32+NUM_EVT-1:32];
        r_ovf_gen  <= cpr_wdata[63];
      end
    end
  end

  assign w_ovf_rd   = 64'(r_ovf) | (64'(r_ovf_mask) << 32) | {r_ovf_gen, 63'b0};
  assign w_ovf_pend = r_ovf_gen & (|(r_ovf & r_ovf_mask));
`else
  assign w_ovf_rd   = '0;
  assign w_ovf_pend = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (cpr_idx)
      IX_STATUS: w_rdata = {62'b0, r_ie, r_emode};
      IX_EPC:    w_rdata = r_epc;
      IX_CAUSE:  w_rdata = 64'(r_cause);
      IX_INST:   w_rdata = 64'(r_inst);
      IX_IMASK:  w_rdata = 64'(r_imask);
      IX_IPND:   w_rdata = 64'(r_ipnd);
      IX_ICNT:   w_rdata = 64'(r_icnt);
      IX_CC:     w_rdata = 64'(r_cc);
      IX_OVF:    w_rdata = w_ovf_rd;
      default:   w_rdata = '0;
    endcase
    for (int k = 0; k < NUM_EVT; k++) begin
      if (cpr_idx == IDX_W'(8 + k)) w_rdata = w_evt_rd[k];
    end
  end

  // Result captures the pre-update value, so MT also returns the old contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result  <= '0;
      r_rvalid  <= 1'b0;
      r_irq_req <= 1'b0;
    end else begin
      r_rvalid  <= enable;
      if (enable) r_result <= w_rdata;
      r_irq_req <= ((|(r_ipnd & r_imask)) | w_ovf_pend) & r_ie & ~r_emode;
    end
  end

  assign irq_req = r_irq_req;
  assign rvalid  = r_rvalid;
  assign result  = r_result;

endmodule
